// File: rtl/conv3x3_engine_pkg.sv
// Shared CNN definitions: word widths, the engine state encoding and the
// ReLU + saturation helper used by every stage that narrows an accumulator.
package conv3x3_engine_pkg;

  localparam int DATA_W = 16;
  localparam int IMG    = 8;
  localparam int K      = 3;
  localparam int OUT    = IMG - K + 1;
  localparam int ACC_W  = 40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Negative sums clamp to zero; sums wider than DATA_W clamp to all-ones.
  function automatic logic [DATA_W-1:0] relu_sat(input logic signed [ACC_W-1:0] acc);
    logic [DATA_W-1:0] res;
    if (acc[ACC_W-1]) begin
      res = {DATA_W{1'b0}};
    end else if (|acc[ACC_W-2:DATA_W]) begin
      res = {DATA_W{1'b1}};
    end else begin
      res = acc[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/conv3x3_engine_mac_relu_sat.sv
// Single multiply-accumulate lane: unsigned pixel times signed weight, with the
// clamped value of the running sum (including the current term) on result.
module conv3x3_engine_mac_relu_sat
  import conv3x3_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] pixel,
  input  logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  base_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [DATA_W:0]   px_s;
  logic signed [DATA_W-1:0] wt_s;
  logic signed [2*DATA_W:0] prod_s;

  // Product and next accumulator value; clr starts a fresh output sum.
  always_comb begin
    px_s   = $signed({1'b0, pixel});
    wt_s   = $signed(weight);
    prod_s = (2*DATA_W+1)'(px_s) * (2*DATA_W+1)'(wt_s);
    if (clr) begin
      base_s = {ACC_W{1'b0}};
    end else begin
      base_s = acc_r;
    end
    sum_s  = base_s + ACC_W'(prod_s);
    result = relu_sat(sum_s);
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (en) begin
      acc_r <= sum_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 valid-region convolution over an 8x8 image: streams in kernel + image,
// then scans 36 outputs with one MAC per cycle into a registered result map.
module conv3x3_engine
  import conv3x3_engine_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] feature_map_out [0:OUT*OUT-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int NW = K * K;
  localparam int NP = IMG * IMG;
  localparam int NO = OUT * OUT;

  state_e            state_r;
  logic [6:0]        cnt_r;
  logic [2:0]        orow_r, ocol_r;
  logic [1:0]        kr_r, kc_r;
  logic [DATA_W-1:0] weight_r [0:NW-1];
  logic [DATA_W-1:0] pixel_r  [0:NP-1];
  logic [DATA_W-1:0] fmap_r   [0:NO-1];
  logic              in_ready_r, out_valid_r, busy_r;

  logic [6:0]        load_idx_s;
  logic [5:0]        row_s, col_s, pix_idx_s, out_idx_s;
  logic [3:0]        w_idx_s;
  logic              mac_en_s, mac_clr_s;
  logic [DATA_W-1:0] mac_res_s;

  // Address generation for the load path and the convolution window.
  always_comb begin
    load_idx_s = cnt_r - 7'd9;
    row_s      = {3'd0, orow_r} + {4'd0, kr_r};
    col_s      = {3'd0, ocol_r} + {4'd0, kc_r};
    pix_idx_s  = {row_s[2:0], 3'b000} + col_s;
    w_idx_s    = ({2'd0, kr_r} * 4'd3) + {2'd0, kc_r};
    out_idx_s  = ({3'd0, orow_r} * 6'd6) + {3'd0, ocol_r};
    mac_en_s   = (state_r == COMPUTE);
    mac_clr_s  = (kr_r == 2'd0) && (kc_r == 2'd0);
  end

  conv3x3_engine_mac_relu_sat u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (mac_en_s),
    .clr    (mac_clr_s),
    .pixel  (pixel_r[pix_idx_s]),
    .weight (weight_r[w_idx_s]),
    .result (mac_res_s)
  );

  // Control FSM, scan counters, operand storage and result map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 7'd0;
      orow_r      <= 3'd0;
      ocol_r      <= 3'd0;
      kr_r        <= 2'd0;
      kc_r        <= 2'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < NW; i++) weight_r[i] <= {DATA_W{1'b0}};
      for (int i = 0; i < NP; i++) pixel_r[i]  <= {DATA_W{1'b0}};
      for (int i = 0; i < NO; i++) fmap_r[i]   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LOAD;
            cnt_r      <= 7'd0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt_r < 7'd9) begin
              weight_r[cnt_r[3:0]] <= in_data;
            end else begin
              pixel_r[load_idx_s[5:0]] <= in_data;
            end
            cnt_r <= cnt_r + 7'd1;
            if (cnt_r == 7'd72) begin
              state_r    <= COMPUTE;
              in_ready_r <= 1'b0;
              orow_r     <= 3'd0;
              ocol_r     <= 3'd0;
              kr_r       <= 2'd0;
              kc_r       <= 2'd0;
            end
          end
        end
        COMPUTE: begin
          if (kc_r == 2'd2) begin
            kc_r <= 2'd0;
            if (kr_r == 2'd2) begin
              kr_r              <= 2'd0;
              fmap_r[out_idx_s] <= mac_res_s;
              if (ocol_r == 3'd5) begin
                ocol_r <= 3'd0;
                if (orow_r == 3'd5) begin
                  orow_r      <= 3'd0;
                  state_r     <= DONE;
                  out_valid_r <= 1'b1;
                end else begin
                  orow_r <= orow_r + 3'd1;
                end
              end else begin
                ocol_r <= ocol_r + 3'd1;
              end
            end else begin
              kr_r <= kr_r + 2'd1;
            end
          end else begin
            kc_r <= kc_r + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_r;
  assign out_valid       = out_valid_r;
  assign busy            = busy_r;
  assign feature_map_out = fmap_r;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: identity, ReLU clamp, saturation,
// backpressure with result hold, mid-run reset and start-pulse robustness.
module tb_conv3x3_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] fmap [0:35];
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int lat;
  logic        same;
  logic [15:0] wts     [0:8];
  logic [15:0] pix     [0:63];
  logic [15:0] exp_map [0:35];
  logic [15:0] ref_map [0:35];

  always #5 clk = ~clk;

  conv3x3_engine dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .feature_map_out (fmap),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Streams 9 weights then 64 pixels; stall=1 gives ~40% in_valid duty.
  task automatic send(input bit stall, input bit glitch);
    int  idx = 0;
    int  iter = 0;
    bit  taken;
    while (idx < 73 && iter < 5000) begin
      in_valid = (!stall) || ($urandom_range(0, 99) < 40);
      if (idx < 9) in_data = wts[idx];
      else         in_data = pix[idx-9];
      start = glitch && (idx == 20);
      taken = in_valid && in_ready;
      @(posedge clk); #1;
      iter++;
      if (taken) idx++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("all_beats_accepted", idx, 32'd73);
  endtask

  // lat counts the cycle of the last beat as cycle 0 plus one per later edge.
  task automatic wait_done(input bit glitch, output int l);
    l = 1;
    while (!out_valid && l < 2000) begin
      start = glitch && (l == 100);
      @(posedge clk); #1;
      l++;
    end
    start = 1'b0;
    chk("out_valid_rises", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic finish_run();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_map(input string tag);
    for (int i = 0; i < 36; i++)
      chk($sformatf("%s[%0d]", tag, i), {16'd0, fmap[i]}, {16'd0, exp_map[i]});
  endtask

  task automatic set_identity();
    for (int i = 0; i < 9; i++)  wts[i] = 16'd0;
    wts[4] = 16'd1;
    for (int i = 0; i < 64; i++) pix[i] = 16'(i);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) exp_map[r*6+c] = 16'((r+1)*8 + c + 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    same = 1'b1;
    for (int i = 0; i < 36; i++) if (fmap[i] !== 16'd0) same = 1'b0;
    chk({tag, "_map_zero"}, {31'd0, same}, 32'd1);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity kernel with latency check.
    set_identity();
    do_start();
    send(1'b0, 1'b0);
    wait_done(1'b0, lat);
    chk("latency_ident", lat, 32'd325);
    check_map("ident");
    finish_run();

    // All weights -1 on positive pixels: every sum negative.
    for (int i = 0; i < 9; i++)  wts[i] = 16'hFFFF;
    for (int i = 0; i < 64; i++) pix[i] = 16'(i + 1);
    for (int i = 0; i < 36; i++) exp_map[i] = 16'd0;
    do_start();
    send(1'b0, 1'b0);
    wait_done(1'b0, lat);
    check_map("relu");
    finish_run();

    // All weights 1 on 0xFFFF pixels: 9*65535 saturates.
    for (int i = 0; i < 9; i++)  wts[i] = 16'd1;
    for (int i = 0; i < 64; i++) pix[i] = 16'hFFFF;
    for (int i = 0; i < 36; i++) exp_map[i] = 16'hFFFF;
    do_start();
    send(1'b0, 1'b0);
    wait_done(1'b0, lat);
    check_map("sat");
    finish_run();

    // Kernel 1..9 over pixel[i]=i: out = 45*(8r+c) + 555.
    for (int i = 0; i < 9; i++)  wts[i] = 16'(i + 1);
    for (int i = 0; i < 64; i++) pix[i] = 16'(i);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) exp_map[r*6+c] = 16'(45*(8*r + c) + 555);
    do_start();
    send(1'b0, 1'b0);
    wait_done(1'b0, lat);
    check_map("ramp");
    for (int i = 0; i < 36; i++) ref_map[i] = exp_map[i];
    finish_run();

    // Same data under input stalls, then result held 50 cycles.
    do_start();
    send(1'b1, 1'b0);
    wait_done(1'b0, lat);
    chk("latency_stalled", lat, 32'd325);
    check_map("stalled");
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      same = 1'b1;
      for (int i = 0; i < 36; i++) if (fmap[i] !== ref_map[i]) same = 1'b0;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_stable", {31'd0, same}, 32'd1);
    end
    finish_run();

    // Start pulses in LOAD, COMPUTE and DONE are ignored.
    set_identity();
    do_start();
    send(1'b0, 1'b1);
    wait_done(1'b1, lat);
    chk("latency_glitch", lat, 32'd325);
    check_map("glitch");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_valid", {31'd0, out_valid}, 32'd1);
    chk("done_start_in_ready", {31'd0, in_ready}, 32'd0);

    // Restart in the first IDLE cycle after acknowledge.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b1;
    chk("ack_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset 100 cycles into COMPUTE.
    send(1'b0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    chk("busy_in_compute", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh run after reset.
    do_start();
    send(1'b0, 1'b0);
    wait_done(1'b0, lat);
    chk("latency_fresh", lat, 32'd325);
    check_map("fresh");
    finish_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

Sequential 3×3 convolution stage that sits directly upstream of the 2×2 max-pool stage. It accepts a 9-word kernel and an 8×8 image over one valid/ready stream, then computes the 6×6 valid-region convolution with one MAC per cycle. ReLU and 16-bit saturation are applied to each result. The result is presented as a flattened 36-entry array, row-major, index r*6+c, which is exactly the pooling stage's input format.

## Interface

Parameters:
- DATA_W, 16, pixel, weight and output word width.
- IMG, 8, input image side.
- K, 3, kernel side; output side OUT = IMG-K+1 = 6.
- ACC_W, 40, accumulator width; must be at least 2*DATA_W+1+ceil(log2(K*K)).

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse; honoured only in IDLE.
- in_data, in, DATA_W, stream word: 9 weights (signed, row-major), then 64 pixels (unsigned, row-major).
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, engine accepts in_data this cycle.
- feature_map_out[0:35], out, DATA_W each, result map, unsigned.
- out_valid, out, 1, feature_map_out holds a complete result.
- out_ready, in, 1, consumer acknowledges the result.
- busy, out, 1, high in every state except IDLE.

## Operation

- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE -> LOAD on start; word counter cleared.
- LOAD: in_ready=1. Each in_valid&&in_ready beat stores one word.
  - Beats 0-8 go to the weight registers.
  - Beats 9-72 go to the pixel array.
  - After beat 72, go to COMPUTE.
  - Stalls on in_valid=0 are unlimited and have no side effects.
- COMPUTE: counters orow, ocol (0..5) and kr, kc (0..2).
  - Each cycle: acc += $signed({1'b0,pixel[(orow+kr)*8+ocol+kc]}) * weight[kr*3+kc].
  - acc clears at kr=kc=0.
  - After the kr=kc=2 term, the result is written to feature_map_out[orow*6+ocol]:
    - acc<0 gives 0;
    - acc>2^DATA_W-1 gives 2^DATA_W-1;
    - otherwise acc[DATA_W-1:0].
  - Scan order is ocol fastest. After output 35 is written, go to DONE.
- DONE: out_valid=1 and feature_map_out holds the result. On out_ready=1, go to IDLE and drop out_valid.
- feature_map_out changes only in COMPUTE. Between runs it holds the previous result.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0).
- Reset (any state, any time):
  - state=IDLE, all counters 0, acc 0;
  - weights and pixels 0, feature_map_out all 0;
  - in_ready=0, out_valid=0, busy=0.

## Timing

- start sampled at edge N gives in_ready=1 from cycle N+1.
- With back-to-back input, 73 beats are accepted in cycles N+1..N+73.
- COMPUTE takes exactly 36*9 = 324 cycles.
- out_valid rises on the cycle after the final write. Total latency from the last input beat to out_valid=1 is 325 cycles.
- out_valid and feature_map_out are registered. out_ready=1 in the same cycle as out_valid gives IDLE on the next edge.
- Back-to-back runs: start may be asserted in the first IDLE cycle.

## Structure

- The shared CNN package holds:
  - DATA_W, IMG, K, OUT, ACC_W;
  - the state enum {IDLE, LOAD, COMPUTE, DONE};
  - a saturate/ReLU function reused by later stages.
- One sub-module is natural: mac_relu_sat, which holds the accumulator, clear/accumulate control, and the ReLU + saturation output.
- FSM, counters and storage live in the top.

## Test plan

- Identity kernel (weight[4]=1, others 0), pixel[i]=i:
  - requires feature_map_out[r*6+c] = (r+1)*8+c+1;
  - requires out_valid exactly 325 cycles after the last beat.
- All weights -1 (0xFFFF), pixels 1..64: requires all 36 outputs = 0 (ReLU clamp).
- All weights 1, all pixels 0xFFFF: requires all outputs = 0xFFFF (saturation, no wrap).
- Stream backpressure:
  - in_valid toggled pseudo-randomly with 40% duty and out_ready held low 50 cycles;
  - requires a result identical to the unstalled run;
  - requires out_valid to stay high and outputs stable until out_ready.
- Reset mid-operation: rst_n low at COMPUTE cycle 100 requires IDLE, all outputs 0, out_valid=0; a fresh run then gives the identity-kernel result.
- Protocol robustness:
  - start pulses during LOAD, COMPUTE and DONE are ignored;
  - a second start in the cycle after out_ready is honoured.
